noc_local_packetizer: RTL

//  Local-endpoint transmitter that injects packets into one node's local port of the mesh fabric.

---
 rtl/noc_local_packetizer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/noc_local_packetizer.sv
// Local-endpoint packetizer: turns a (dst, vc, len) request plus a stream of
// payload words into head/body/tail flits for the node's fabric local port.
// Ports:
//   noc_clk, noc_rst_n          clock, async active-low reset
//   id_x, id_y                  own node coordinates (static)
//   req_*                       packet request handshake and fields
//   data_valid/data_ready/data  payload word stream
//   flit_valid/flit_ready       flit handshake toward the fabric
//   flit_vc, flit               flit VC and {type[1:0], payload}
//   vc_ready                    per-VC downstream space
//   busy, pkt_done              packet in progress / last-flit-accepted pulse
module noc_local_packetizer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned VC_NUM = 2,
  parameter int unsigned ID_X_W = 2,
  parameter int unsigned ID_Y_W = 2,
  parameter int unsigned LEN_W  = 4,
  localparam int unsigned VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                noc_clk,
  input  logic                noc_rst_n,
  input  logic [ID_X_W-1:0]   id_x,
  input  logic [ID_Y_W-1:0]   id_y,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ID_X_W-1:0]   req_dst_x,
  input  logic [ID_Y_W-1:0]   req_dst_y,
  input  logic [VC_W-1:0]     req_vc,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [DATA_W-1:0]   data,
  output logic                flit_valid,
  input  logic                flit_ready,
  output logic [VC_W-1:0]     flit_vc,
  output logic [DATA_W+1:0]   flit,
  input  logic [VC_NUM-1:0]   vc_ready,
  output logic                busy,
  output logic                pkt_done
);

  localparam int unsigned FLIT_W = DATA_W + 2;

  localparam logic [1:0] FT_HEAD   = 2'b00;
  localparam logic [1:0] FT_BODY   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_X_W-1:0]   dst_x_q, dst_x_d;
  logic [ID_Y_W-1:0]   dst_y_q, dst_y_d;
  logic [VC_W-1:0]     vc_q, vc_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                flit_valid_q, flit_valid_d;
  logic [FLIT_W-1:0]   flit_q, flit_d;
  logic [VC_W-1:0]     flit_vc_q, flit_vc_d;

  logic loadable_c;
  logic vc_ok_c;
  logic req_fire_c;
  logic load_head_c;
  logic load_body_c;

  // State register and datapath flops
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_q      <= ST_IDLE;
      dst_x_q      <= '0;
      dst_y_q      <= '0;
      vc_q         <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      flit_vc_q    <= '0;
    end else begin
      state_q      <= state_d;
      dst_x_q      <= dst_x_d;
      dst_y_q      <= dst_y_d;
      vc_q         <= vc_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      flit_valid_q <= flit_valid_d;
      flit_q       <= flit_d;
      flit_vc_q    <= flit_vc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_fire_c) state_d = ST_HEAD;
      ST_HEAD: if (load_head_c) state_d = (len_q == '0) ? ST_IDLE : ST_BODY;
      ST_BODY: if (load_body_c && (cnt_q == LEN_W'(1))) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake decode and output-register loading
  always_comb begin
    req_ready   = 1'b0;
    data_ready  = 1'b0;
    load_head_c = 1'b0;
    load_body_c = 1'b0;
    dst_x_d      = dst_x_q;
    dst_y_d      = dst_y_q;
    vc_d         = vc_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    flit_valid_d = flit_valid_q;
    flit_d       = flit_q;
    flit_vc_d    = flit_vc_q;

    // The single output slot can take a new flit if empty or draining now.
    loadable_c = !flit_valid_q || flit_ready;
    vc_ok_c    = vc_ready[vc_q];

    unique case (state_q)
      ST_IDLE: req_ready = loadable_c;
      ST_HEAD: load_head_c = vc_ok_c && loadable_c;
      ST_BODY: begin
        data_ready  = vc_ok_c && loadable_c;
        load_body_c = data_ready && data_valid;
      end
      default: ;
    endcase

    req_fire_c = req_valid && req_ready;

    if (req_fire_c) begin
      dst_x_d = req_dst_x;
      dst_y_d = req_dst_y;
      vc_d    = req_vc;
      len_d   = req_len;
      cnt_d   = req_len;
    end

    if (flit_valid_q && flit_ready) flit_valid_d = 1'b0;

    if (load_head_c) begin
      flit_valid_d = 1'b1;
      flit_vc_d    = vc_q;
      flit_d       = {(len_q == '0) ? FT_SINGLE : FT_HEAD,
                      DATA_W'({len_q, id_y, id_x, dst_y_q, dst_x_q})};
    end

    if (load_body_c) begin
      flit_valid_d = 1'b1;
      flit_vc_d    = vc_q;
      flit_d       = {(cnt_q == LEN_W'(1)) ? FT_TAIL : FT_BODY, data};
      cnt_d        = cnt_q - LEN_W'(1);
    end
  end

  assign flit_valid = flit_valid_q;
  assign flit       = flit_q;
  assign flit_vc    = flit_vc_q;
  assign busy       = (state_q != ST_IDLE) || flit_valid_q;
  // Type bit 1 is set only for tail (10) and single (11) flits.
  assign pkt_done   = flit_valid_q && flit_ready && flit_q[FLIT_W-1];

endmodule
